// File: rtl/fp_det_pkg.sv
// rtl/fp_det_pkg.sv - shared constants, FSM states and index helper for the determinant datapath
package fp_det_pkg;

    localparam int MAX_N  = 5;
    localparam int WORD_W = 32;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET_N  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    // Row-major flat index; storage is always laid out on a MAX_N stride.
    function automatic logic [4:0] idx(input logic [2:0] r, input logic [2:0] c);
        return 5'(r) * 5'(MAX_N) + 5'(c);
    endfunction

endpackage

// File: rtl/fp_matrix_store.sv
// rtl/fp_matrix_store.sv - matrix register array with one write port, clear-by-index and flat read bus
module fp_matrix_store #(
    parameter int DEPTH  = 25,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [WORD_W-1:0]       wdata,
    input  logic                    clr,
    input  logic [IDX_W-1:0]        cidx,
    output logic [DEPTH*WORD_W-1:0] mat_flat
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr && (int'(cidx) < DEPTH)) begin
                mem[cidx] <= '0;
            end else if (we && (int'(widx) < DEPTH)) begin
                mem[widx] <= wdata;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mat_flat[g*WORD_W +: WORD_W] = mem[g];
    end

endmodule

// File: rtl/fp_matrix_loader.sv
// rtl/fp_matrix_loader.sv - custom-instruction front end that loads a matrix and runs the determinant engine
module fp_matrix_loader #(
    parameter int MAX_N  = 5,
    parameter int WORD_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          start,
    input  logic [31:0]                   dataa,
    input  logic [31:0]                   datab,
    output logic                          done,
    output logic [31:0]                   result,
    output logic [MAX_N*MAX_N*WORD_W-1:0] mat_flat,
    output logic [4:0]                    n_out,
    output logic                          det_start,
    input  logic                          det_done,
    input  logic [31:0]                   det_result
);
    import fp_det_pkg::*;

    localparam int IDX_W = $clog2(MAX_N*MAX_N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_N*MAX_N-1);

    state_t           state;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_row;
    logic [2:0]       cmd_col;
    logic [31:0]      cmd_data;
    logic [IDX_W-1:0] clr_cnt;
    logic             det_pend;
    logic [31:0]      det_res_q;

    logic wr_ok;
    logic set_ok;
    logic store_we;
    logic store_clr;
    logic unused_datab;

    assign unused_datab = ^{datab[29:7], datab[3]};

    assign wr_ok  = ({2'b00, cmd_row} < n_out) && ({2'b00, cmd_col} < n_out);
    assign set_ok = (cmd_data >= 32'd1) && (cmd_data <= 32'(MAX_N));

    assign store_we  = clk_en && (state == S_EXEC) && (cmd_op == OP_WRITE) && wr_ok;
    assign store_clr = clk_en && (state == S_CLEAR);

    fp_matrix_store #(
        .DEPTH  (MAX_N*MAX_N),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .we       (store_we),
        .widx     (IDX_W'(idx(cmd_row, cmd_col))),
        .wdata    (cmd_data),
        .clr      (store_clr),
        .cidx     (clr_cnt),
        .mat_flat (mat_flat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            result    <= '0;
            n_out     <= 5'(MAX_N);
            det_start <= 1'b0;
            clr_cnt   <= '0;
            cmd_op    <= OP_WRITE;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_data  <= '0;
            det_pend  <= 1'b0;
            det_res_q <= '0;
        end else begin
            // The engine sees a single raw-clock launch pulse even if clk_en drops.
            det_start <= 1'b0;
            if (!clk_en) begin
                if (det_done) begin
                    det_pend  <= 1'b1;
                    det_res_q <= det_result;
                end
            end else begin
                det_pend <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cmd_op   <= datab[31:30];
                            cmd_row  <= datab[6:4];
                            cmd_col  <= datab[2:0];
                            cmd_data <= dataa;
                            clr_cnt  <= '0;
                            case (datab[31:30])
                                OP_CLEAR:  state <= S_CLEAR;
                                OP_COMMIT: begin
                                    state     <= S_LAUNCH;
                                    det_start <= 1'b1;
                                end
                                default:   state <= S_EXEC;
                            endcase
                        end
                    end
                    S_EXEC: begin
                        done  <= 1'b1;
                        state <= S_RESP;
                        if (cmd_op == OP_WRITE) begin
                            result <= wr_ok ? 32'd0 : ERR_RESULT;
                        end else if (set_ok) begin
                            n_out  <= cmd_data[4:0];
                            result <= 32'd0;
                        end else begin
                            result <= ERR_RESULT;
                        end
                    end
                    S_CLEAR: begin
                        if (clr_cnt == LAST_IDX) begin
                            done   <= 1'b1;
                            result <= 32'd0;
                            state  <= S_RESP;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    S_LAUNCH: begin
                        state <= S_WAIT;
                        if (det_done) begin
                            det_pend  <= 1'b1;
                            det_res_q <= det_result;
                        end else begin
                            det_pend <= det_pend;
                        end
                    end
                    S_WAIT: begin
                        if (det_done || det_pend) begin
                            done   <= 1'b1;
                            result <= det_pend ? det_res_q : det_result;
                            state  <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_matrix_loader.sv
// tb/tb_fp_matrix_loader.sv - scoreboard bench for the matrix loader custom instruction
module tb_fp_matrix_loader;

    localparam logic [1:0] W_OP = 2'b00, N_OP = 2'b01, C_OP = 2'b10, K_OP = 2'b11;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset, clk_en, start, det_done;
    logic [31:0]  dataa, datab, det_result;
    logic         done, det_start;
    logic [31:0]  result;
    logic [799:0] mat_flat;
    logic [4:0]   n_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model [25];
    logic [31:0] exp_q [$];

    fp_matrix_loader #(.MAX_N(5), .WORD_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .done       (done),
        .result     (result),
        .mat_flat   (mat_flat),
        .n_out      (n_out),
        .det_start  (det_start),
        .det_done   (det_done),
        .det_result (det_result)
    );

    always #5 clk = ~clk;

    function automatic logic [799:0] model_flat();
        logic [799:0] v;
        for (int i = 0; i < 25; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < 25; i++) if (mat_flat[32*i +: 32] !== model[i]) return i;
        return -1;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] row, input logic [2:0] col,
                          input logic [31:0] data, output int lat, output logic [31:0] res);
        lat = -1;
        res = 'x;
        @(negedge clk);
        start = 1'b1;
        dataa = data;
        datab = {op, 23'd0, row, 1'b0, col};
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (n_out !== 5'd5) begin n_err++; $display("FAIL reset_n_out got %0d want 5", n_out); end
        n_cmp++; if (mat_flat !== '0) begin n_err++; $display("FAIL reset_matrix first nonzero word %0d", first_diff()); end
        n_cmp++; if (done !== 1'b0 || det_start !== 1'b0) begin n_err++; $display("FAIL reset_pulses done=%b det_start=%b want 0/0", done, det_start); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (result !== 32'd0 || done !== 1'b0) begin n_err++; $display("FAIL post_reset result=%h done=%b want 0/0", result, done); end
    endtask

    task automatic test_write();
        int lat;
        logic [31:0] res, e;
        exp_q.push_back(32'd0);
        do_cmd(W_OP, 3'd2, 3'd3, 32'h3F80_0000, lat, res);
        model[13] = 32'h3F80_0000;
        e = exp_q.pop_front();
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL write_result got %h want %h", res, e); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL write_latency got %0d want 2", lat); end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL write_matrix word %0d wrong, word13=%h want 3f800000", first_diff(), mat_flat[13*32 +: 32]); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || result !== 32'd0) begin n_err++; $display("FAIL write_done_width done=%b result=%h want 0/0", done, result); end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [31:0] data;
        logic [31:0] er;
        logic [4:0]  en;
    } step_t;

    task automatic test_set_n();
        step_t s [10];
        int lat;
        logic [31:0] res, e;
        s[0] = '{N_OP, 3'd0, 3'd0, 32'd3,          32'd0, 5'd3};
        s[1] = '{W_OP, 3'd4, 3'd0, 32'h1234_5678,  ERR,   5'd3};
        s[2] = '{N_OP, 3'd0, 3'd0, 32'd7,          ERR,   5'd3};
        s[3] = '{N_OP, 3'd0, 3'd0, 32'd0,          ERR,   5'd3};
        s[4] = '{W_OP, 3'd2, 3'd2, 32'h4040_0000,  32'd0, 5'd3};
        s[5] = '{W_OP, 3'd1, 3'd3, 32'h0000_0005,  ERR,   5'd3};
        s[6] = '{N_OP, 3'd0, 3'd0, 32'd1,          32'd0, 5'd1};
        s[7] = '{W_OP, 3'd0, 3'd1, 32'h0000_0009,  ERR,   5'd1};
        s[8] = '{N_OP, 3'd0, 3'd0, 32'h0000_0105,  ERR,   5'd1};
        s[9] = '{N_OP, 3'd0, 3'd0, 32'd5,          32'd0, 5'd5};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(s[i].er);
            do_cmd(s[i].op, s[i].row, s[i].col, s[i].data, lat, res);
            if (s[i].op == W_OP && s[i].er == 32'd0) model[s[i].row*5 + s[i].col] = s[i].data;
            e = exp_q.pop_front();
            n_cmp++; if (res !== e) begin n_err++; $display("FAIL setn_step%0d_result got %h want %h", i, res, e); end
            n_cmp++; if (lat != 2) begin n_err++; $display("FAIL setn_step%0d_latency got %0d want 2", i, lat); end
            n_cmp++; if (n_out !== s[i].en) begin n_err++; $display("FAIL setn_step%0d_n_out got %0d want %0d", i, n_out, s[i].en); end
            n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL setn_step%0d_matrix word %0d differs", i, first_diff()); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] res, e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'd0);
            do_cmd(W_OP, 3'd4, 3'(i), 32'hA000_0000 + i, lat, res);
            model[20 + i] = 32'hA000_0000 + i;
            e = exp_q.pop_front();
            n_cmp++; if (res !== e || lat != 2) begin n_err++; $display("FAIL b2b_%0d result=%h lat=%0d want %h/2", i, res, lat, e); end
        end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL b2b_matrix word %0d differs", first_diff()); end
    endtask

    task automatic load_2x2();
        int lat;
        logic [31:0] res, e;
        step_t s [5];
        s[0] = '{N_OP, 3'd0, 3'd0, 32'd2,         32'd0, 5'd2};
        s[1] = '{W_OP, 3'd0, 3'd0, 32'h4000_0000, 32'd0, 5'd2};
        s[2] = '{W_OP, 3'd0, 3'd1, 32'h0000_0000, 32'd0, 5'd2};
        s[3] = '{W_OP, 3'd1, 3'd0, 32'h0000_0000, 32'd0, 5'd2};
        s[4] = '{W_OP, 3'd1, 3'd1, 32'h4040_0000, 32'd0, 5'd2};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(s[i].er);
            do_cmd(s[i].op, s[i].row, s[i].col, s[i].data, lat, res);
            if (s[i].op == W_OP) model[s[i].row*5 + s[i].col] = s[i].data;
            e = exp_q.pop_front();
            n_cmp++; if (res !== e || lat != 2) begin n_err++; $display("FAIL load2x2_%0d result=%h lat=%0d want %h/2", i, res, lat, e); end
        end
    endtask

    task automatic test_commit();
        int ds_cnt = 0, ds_at = -1, done_cnt = 0, done_at = -1;
        logic [31:0] res = 'x, e;
        load_2x2();
        exp_q.push_back(32'h40C0_0000);
        @(negedge clk);
        start = 1'b1;
        dataa = 32'd0;
        datab = {C_OP, 30'd0};
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (det_start === 1'b1) begin ds_cnt++; if (ds_at < 0) ds_at = k; end
            if (done === 1'b1) begin done_cnt++; if (done_at < 0) begin done_at = k; res = result; end end
            if (ds_at > 0 && k == ds_at + 40) begin
                det_done = 1'b1;
                det_result = 32'h40C0_0000;
            end else begin
                det_done = 1'b0;
                det_result = 32'hDEAD_BEEF;
            end
            if (k == 10) begin
                start = 1'b1;
                dataa = 32'hFFFF_0000;
                datab = {W_OP, 30'd0};
            end
            if (k == 11) start = 1'b0;
            if (k > 1 && k < 42 && (mat_flat !== model_flat() || n_out !== 5'd2)) begin
                n_cmp++; n_err++;
                $display("FAIL commit_stable cycle %0d n_out=%0d word %0d differs", k, n_out, first_diff());
            end
        end
        e = exp_q.pop_front();
        n_cmp++; if (ds_cnt != 1 || ds_at != 1) begin n_err++; $display("FAIL commit_det_start count=%0d at=%0d want 1/1", ds_cnt, ds_at); end
        n_cmp++; if (done_at != 42 || done_cnt != 1) begin n_err++; $display("FAIL commit_done at=%0d count=%0d want 42/1", done_at, done_cnt); end
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL commit_result got %h want %h", res, e); end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL commit_ignored_start word %0d changed", first_diff()); end
    endtask

    task automatic test_commit_gated();
        int ds_cnt = 0, done_at = -1;
        logic [31:0] res = 'x, e;
        exp_q.push_back(32'hC0A0_0000);
        @(negedge clk);
        start = 1'b1;
        datab = {C_OP, 30'd0};
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (det_start === 1'b1) ds_cnt++;
            if (done === 1'b1 && done_at < 0) begin done_at = k; res = result; end
            clk_en = !(k >= 5 && k <= 7);
            det_done = (k == 5);
            det_result = (k == 5) ? 32'hC0A0_0000 : 32'h1111_1111;
        end
        clk_en = 1'b1;
        det_done = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (ds_cnt != 1) begin n_err++; $display("FAIL gated_commit_det_start count=%0d want 1", ds_cnt); end
        n_cmp++; if (done_at != 9) begin n_err++; $display("FAIL gated_commit_done at=%0d want 9", done_at); end
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL gated_commit_result got %h want %h", res, e); end
    endtask

    task automatic test_clear(input bit gated);
        int lat, done_at = -1, en_cnt = 0;
        logic [31:0] res, e;
        exp_q.push_back(32'd0);
        do_cmd(N_OP, 3'd0, 3'd0, 32'd5, lat, res);
        e = exp_q.pop_front();
        n_cmp++; if (res !== e || n_out !== 5'd5) begin n_err++; $display("FAIL clear_setn result=%h n_out=%0d want %h/5", res, n_out, e); end
        for (int i = 0; i < 25; i++) begin
            exp_q.push_back(32'd0);
            do_cmd(W_OP, 3'(i / 5), 3'(i % 5), 32'h3F00_0000 + (gated ? 32'h100 : 32'h0) + i, lat, res);
            model[i] = 32'h3F00_0000 + (gated ? 32'h100 : 32'h0) + i;
            e = exp_q.pop_front();
            if (res !== e || lat != 2) begin n_cmp++; n_err++; $display("FAIL fill_%0d result=%h lat=%0d want %h/2", i, res, lat, e); end
        end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL fill_matrix word %0d differs", first_diff()); end
        exp_q.push_back(32'd0);
        @(negedge clk);
        start = 1'b1;
        datab = {K_OP, 30'd0};
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            for (int j = 0; j < 25; j++) if (j < en_cnt) model[j] = 32'd0;
            n_cmp++;
            if (mat_flat !== model_flat()) begin
                n_err++;
                $display("FAIL clear_order gated=%0d cycle %0d word %0d got %h want %h", gated, k, first_diff(),
                         mat_flat[32*((first_diff() < 0) ? 0 : first_diff()) +: 32], model[(first_diff() < 0) ? 0 : first_diff()]);
            end
            if (done === 1'b1) begin done_at = k; res = result; break; end
            clk_en = gated ? (k % 2 == 1) : 1'b1;
            if (clk_en) en_cnt++;
        end
        clk_en = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (done_at != (gated ? 50 : 26)) begin n_err++; $display("FAIL clear_done gated=%0d at=%0d want %0d", gated, done_at, gated ? 50 : 26); end
        n_cmp++; if (res !== e || mat_flat !== '0) begin n_err++; $display("FAIL clear_final gated=%0d result=%h word %0d nonzero", gated, res, first_diff()); end
    endtask

    task automatic test_reset_in_wait();
        int lat, ds_at = -1, done_cnt = 0;
        logic [31:0] res, e;
        exp_q.push_back(32'd0);
        do_cmd(N_OP, 3'd0, 3'd0, 32'd3, lat, res);
        e = exp_q.pop_front();
        n_cmp++; if (res !== e) begin n_err++; $display("FAIL rw_setn result=%h want %h", res, e); end
        do_cmd(W_OP, 3'd0, 3'd0, 32'h3F80_0000, lat, res);
        @(negedge clk);
        start = 1'b1;
        datab = {C_OP, 30'd0};
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (det_start === 1'b1 && ds_at < 0) ds_at = k;
        end
        n_cmp++; if (ds_at != 1) begin n_err++; $display("FAIL rw_det_start at=%0d want 1", ds_at); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 25; i++) model[i] = 32'd0;
        @(negedge clk);
        det_done = 1'b1;
        det_result = 32'h1234_5678;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            det_done = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rw_no_done count=%0d want 0", done_cnt); end
        n_cmp++; if (n_out !== 5'd5 || result !== 32'd0) begin n_err++; $display("FAIL rw_state n_out=%0d result=%h want 5/0", n_out, result); end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL rw_matrix word %0d nonzero", first_diff()); end
        exp_q.push_back(32'd0);
        do_cmd(W_OP, 3'd4, 3'd4, 32'h4120_0000, lat, res);
        model[24] = 32'h4120_0000;
        e = exp_q.pop_front();
        n_cmp++; if (res !== e || lat != 2) begin n_err++; $display("FAIL rw_idle_write result=%h lat=%0d want %h/2", res, lat, e); end
        n_cmp++; if (mat_flat !== model_flat()) begin n_err++; $display("FAIL rw_idle_matrix word %0d differs", first_diff()); end
    endtask

    initial begin
        reset = 1'b0;
        clk_en = 1'b1;
        start = 1'b0;
        dataa = '0;
        datab = '0;
        det_done = 1'b0;
        det_result = '0;
        for (int i = 0; i < 25; i++) model[i] = 32'd0;
        test_reset();
        test_write();
        test_set_n();
        test_back_to_back();
        test_commit();
        test_commit_gated();
        test_clear(1'b0);
        test_clear(1'b1);
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_matrix_loader.md
# fp_matrix_loader

Upstream front end for the floating-point determinant engine. Presents a Nios II multi-cycle custom-instruction interface to the CPU. Accumulates an up-to-5×5 single-precision matrix one element per instruction and holds the matrix dimension. On a COMMIT command it launches the determinant engine, waits for completion, and returns the determinant as the custom-instruction result.

## Interface
Parameters:
- MAX_N, 5, maximum matrix dimension; storage is MAX_N×MAX_N words
- WORD_W, 32, element width (IEEE-754 single)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous assert, active-low; one clock, no other resets
- clk_en  in  1  custom-instruction clock enable; when low, all state, counters and outputs hold
- start  in  1  custom-instruction start; sampled only when clk_en=1
- dataa  in  32  operand: element value (WRITE) or dimension (SET_N)
- datab  in  32  command word: [31:30] op, [6:4] row, [2:0] col
- done  out  1  one-cycle completion pulse to CPU
- result  out  32  instruction result; valid while done=1, held afterwards
- mat_flat  out  MAX_N*MAX_N*32  matrix to engine; element (r,c) at bits [32*(5r+c)+31 : 32*(5r+c)]
- n_out  out  5  current dimension to engine
- det_start  out  1  one-cycle launch pulse to engine
- det_done  in  1  engine completion pulse
- det_result  in  32  engine determinant; sampled when det_done=1

## Operation
Opcodes in datab[31:30]:
- WRITE (00): store dataa at (row,col); if row≥n_out or col≥n_out, nothing is stored and result=32'hFFFF_FFFF; otherwise result=0
- SET_N (01): if dataa ∈ 1..5, n_out←dataa and result=0; otherwise n_out is unchanged and result=32'hFFFF_FFFF
- COMMIT (10): pulse det_start, wait for det_done, return det_result
- CLEAR (11): zero all 25 elements sequentially, one element per enabled cycle, index 0..24; result=0

FSM states and transitions:
- IDLE: start & clk_en → EXEC (WRITE/SET_N), CLEAR, or LAUNCH
- EXEC → RESP
- CLEAR: counter reaches 24 → RESP
- LAUNCH → WAIT
- WAIT: det_done → RESP
- RESP → IDLE

Rules:
- start is ignored unless the FSM is in IDLE; there is no queueing
- Reset values: done=0, result=0, mat_flat=0, n_out=5, det_start=0, FSM=IDLE, clear counter=0
- Reset mid-operation, including WAIT: return to reset state immediately; no done is issued; a later det_done is ignored while in IDLE
- A det_done arriving in a cycle with clk_en=0 is latched and acted on at the next enabled cycle
- mat_flat and n_out stay stable from LAUNCH until exit from WAIT; commands are not accepted in that window

## Timing
All latencies count enabled cycles from the start edge at cycle t:
- WRITE/SET_N: storage updated at the t+1 edge; done=1 in cycle t+2
- CLEAR: element k is zeroed at the t+1+k edge; done=1 in cycle t+26
- COMMIT: det_start=1 in cycle t+1; if det_done is seen in cycle d, done=1 and result=det_result in cycle d+1
- done is high for exactly one enabled cycle; det_start is high for exactly one cycle
- Back-to-back: start is accepted in the cycle after done

## Structure
- Shared package fp_det_pkg holds: MAX_N, opcode localparams (OP_WRITE, OP_SET_N, OP_COMMIT, OP_CLEAR), ERR_RESULT=32'hFFFF_FFFF, the FSM state enum, and the flat-index function idx(r,c)=5r+c. The determinant engine reuses the package.
- Sub-module fp_matrix_store: 25-word register array with one write port (index, data, we), a synchronous-clear-by-index path, and the flattened read bus.
- The top level holds the FSM, command decode, clear counter, and the det handshake.

## Test plan
- After reset: n_out=5, mat_flat all zero, done=0; issue WRITE dataa=32'h3F80_0000, row=2, col=3 → word 13 = 32'h3F80_0000, done in cycle t+2, result=0.
- SET_N dataa=3, then WRITE row=4 col=0 → result=32'hFFFF_FFFF and word 20 unchanged; SET_N dataa=7 → result=ERR and n_out stays 3.
- Load 2×2 [[2,0],[0,3]], COMMIT; engine model asserts det_done with det_result=32'h40C0_0000 after 40 cycles → one det_start pulse, done one cycle later, result=32'h40C0_0000.
- Fill all 25 words with nonzero values, CLEAR → each word zero in index order, one per cycle, done at t+26; with clk_en toggled low every other cycle, done is delayed accordingly with no lost index.
- Assert reset in WAIT, then deliver det_done after release → no done pulse, FSM in IDLE, n_out=5, matrix zero; a start issued during WAIT (no reset) is ignored.
